from_serial: RTL and testbench
==============================

# from_serial

Digit-serial to parallel converter: the receive-side counterpart of `to_serial`. It collects `BW_OUT/BW_IN` consecutive valid digits per channel, least-significant digit first, and emits one parallel `BW_OUT`-bit word per channel with a single-cycle `vld_out` pulse. Typical placement is after a serial conv stage and before a parallel consumer, such as the flatten into `dense_layer_fp`, or a debug tap on a serial bus.

## Interface
Parameters:
- `NO_CH`, 1, number of independent channels; all channels share one valid and one digit counter.
- `BW_IN`, 4, digit width per channel per cycle.
- `BW_OUT`, 16, assembled word width. Must be an integer multiple of `BW_IN`, with `BW_OUT >= BW_IN`.
- `CYC`, derived as `BW_OUT/BW_IN`. Digits per word.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `vld_in`, in, 1: digit valid; the digit on `data_in` is accepted this cycle.
- `sof`, in, 1: start of word. Qualified by `vld_in`; marks the current digit as digit 0.
- `data_in`, in, `NO_CH*BW_IN`: channel `i` occupies bits `[i*BW_IN +: BW_IN]`.
- `vld_out`, out, 1: one-cycle pulse; `data_out` holds a complete word.
- `data_out`, out, `NO_CH*BW_OUT`: channel `i` occupies bits `[i*BW_OUT +: BW_OUT]`.
- `frame_err`, out, 1: sticky flag; set when a partial word is discarded by `sof`.

## Operation
- Digit counter `cnt`, width `max(1,$clog2(CYC))`; reset value 0.
- Shift register per channel, `BW_OUT` bits. On an accepted digit, the digit enters at the MSB end and the register shifts right by `BW_IN`. After `CYC` digits, digit 0 occupies bits `[BW_IN-1:0]`.
- On `vld_in & ~sof`:
  - If `cnt == CYC-1`: word complete; `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
- On `vld_in & sof`:
  - The shift register is restarted: the digit is loaded as digit 0 and prior partial contents are discarded.
  - `cnt <= 1`. When `CYC==1`, the word completes immediately and `cnt` stays 0.
  - If `cnt != 0` at this time, `frame_err <= 1`. It is cleared only by `rst`.
- `sof` with `vld_in` low is ignored.
- `vld_in` low: no state change. Gaps between digits of any length are legal; the partial word is held.
- On word completion, the assembled word is written to the output register and `vld_out` is asserted for the next cycle only.
- Back-to-back words with no gap are supported: completion, then digit 0 of the next word on the following cycle.
- No backpressure. The consumer must accept every `vld_out` pulse.
- `CYC==1`: every accepted digit is a word; the block acts as a one-cycle register.
- All channels are lane-parallel; there is no cross-channel arithmetic. Data is not sign-extended and not interpreted.

## Timing
- Reset values: `vld_out=0`, `data_out=0`, `frame_err=0`, `cnt=0`, shift registers 0.
- Latency: `vld_out` rises exactly 1 cycle after the clock edge that accepts the last digit (digit `CYC-1`).
- Throughput: one word per `CYC` accepted digits. The maximum is one word per `CYC` cycles.
- `rst` mid-word: the partial word is dropped. The first accepted digit after reset is digit 0, regardless of `sof`.
- `rst` has priority over all other inputs in the same cycle.
- A `vld_out` pulse pending in the output register at the time of `rst` is cancelled.
- `frame_err` rises 1 cycle after the offending `sof` digit is accepted.

## Configuration
- Macro: `FROM_SERIAL_HOLD_EN`.
- Defined: `data_out` holds the last completed word until the next completion or `rst`.
- Undefined: `data_out` is forced to 0 in every cycle where `vld_out` is 0. This keeps downstream OR-based muxing legal.
- `vld_out` timing is identical in both builds.

## Test plan
- Basic assembly (`NO_CH=2`, `BW_IN=4`, `BW_OUT=16`):
  - Stimulus: ch0 digits 0x4,0x3,0x2,0x1 and ch1 digits 0xD,0xC,0xB,0xA on 4 consecutive `vld_in` cycles, `sof` on the first.
  - Required: 1 cycle after the 4th digit, a single `vld_out` pulse with `data_out` = {0xABCD, 0x1234}.
- Gapped input:
  - Stimulus: same digits with 3 idle cycles between each.
  - Required: identical output, 1 cycle after the 4th digit; no extra pulses.
- Back-to-back words:
  - Stimulus: 8 consecutive digits forming 0x1234 then 0x5678 on ch0.
  - Required: `vld_out` pulses at cycle offsets 4 and 8 from the first digit, with the correct words; `frame_err=0`.
- Misframe:
  - Stimulus: 2 digits, then `sof` plus 4 digits forming 0xBEEF.
  - Required: `frame_err` is 1 from the cycle after the `sof`, and exactly one word 0xBEEF is emitted.
- Reset mid-word:
  - Stimulus: 3 digits, `rst` for 1 cycle, then 4 digits forming 0x00FF with no `sof`.
  - Required: `cnt` returns to 0, one word 0x00FF is emitted, and no output comes from the pre-reset digits.
- Hold macro:
  - Stimulus: after word 0x1234, 5 idle cycles.
  - Required: with `FROM_SERIAL_HOLD_EN`, `data_out` stays 0x1234; without it, `data_out` is 0 in those 5 cycles.

Source files
------------

// File: rtl/from_serial_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | from_serial_if                                                       |
// | Digit-serial input / parallel word output bundle for from_serial.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface from_serial_if #(
  parameter int NO_CH  = 1,
  parameter int BW_IN  = 4,
  parameter int BW_OUT = 16
);
  logic                    vld_in;
  logic                    sof;
  logic [NO_CH*BW_IN-1:0]  data_in;
  logic                    vld_out;
  logic [NO_CH*BW_OUT-1:0] data_out;
  logic                    frame_err;

  modport master (
    output vld_in, sof, data_in,
    input  vld_out, data_out, frame_err
  );

  modport slave (
    input  vld_in, sof, data_in,
    output vld_out, data_out, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/from_serial.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | from_serial                                                          |
// | Collects BW_OUT/BW_IN digits per channel (LSD first) into one word.  |
// | Macro FROM_SERIAL_HOLD_EN: data_out holds the last completed word.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module from_serial #(
  parameter int NO_CH  = 1,
  parameter int BW_IN  = 4,
  parameter int BW_OUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  from_serial_if.slave  bus
);
  localparam int CYC   = BW_OUT / BW_IN;
  localparam int CNT_W = (CYC > 1) ? $clog2(CYC) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CYC - 1);
  localparam logic [CNT_W-1:0] C_CNT_SOF  = (CYC == 1) ? '0 : CNT_W'(1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NO_CH*BW_OUT-1:0] sr_q, sr_d;
  logic [NO_CH*BW_OUT-1:0] data_q, data_d;
  logic                    vld_q, done_d;
  logic                    ferr_q, ferr_d;

  // New digit enters at the MSB end; sof drops the partial word instead of shifting it.
  for (genvar gi = 0; gi < NO_CH; gi++) begin : g_ch
    logic [BW_OUT-1:0] w_top;
    assign w_top = BW_OUT'(bus.data_in[gi*BW_IN +: BW_IN]) << (BW_OUT - BW_IN);
    assign sr_d[gi*BW_OUT +: BW_OUT] =
      bus.sof ? w_top : (w_top | (sr_q[gi*BW_OUT +: BW_OUT] >> BW_IN));
  end

  always_comb begin
    done_d = bus.vld_in & (bus.sof ? (CYC == 1) : (cnt_q == C_CNT_LAST));
    ferr_d = ferr_q | (bus.vld_in & bus.sof & (cnt_q != '0));
    cnt_d  = cnt_q;
    if (bus.vld_in) begin
      if (bus.sof)                 cnt_d = C_CNT_SOF;
      else if (cnt_q == C_CNT_LAST) cnt_d = '0;
      else                         cnt_d = cnt_q + 1'b1;
    end
`ifdef FROM_SERIAL_HOLD_EN
    data_d = done_d ? sr_d : data_q;
`else
    data_d = done_d ? sr_d : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sr_q   <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      if (bus.vld_in) sr_q <= sr_d;
      data_q <= data_d;
      vld_q  <= done_d;
      ferr_q <= ferr_d;
    end
  end

  assign bus.vld_out   = vld_q;
  assign bus.data_out  = data_q;
  assign bus.frame_err = ferr_q;
endmodule
`default_nettype wire

// File: tb/tb_from_serial.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_from_serial                                                       |
// | Scoreboard bench: directed framing cases plus random digit streams.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_from_serial;
  localparam int NO_CH  = 2;
  localparam int BW_IN  = 4;
  localparam int BW_OUT = 16;
  localparam int CYC    = BW_OUT / BW_IN;
  localparam int DW_IN  = NO_CH * BW_IN;
  localparam int DW_OUT = NO_CH * BW_OUT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  from_serial_if #(.NO_CH(NO_CH), .BW_IN(BW_IN), .BW_OUT(BW_OUT)) bus ();

  from_serial #(.NO_CH(NO_CH), .BW_IN(BW_IN), .BW_OUT(BW_OUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW_OUT-1:0] exp_q[$];
  logic [DW_IN-1:0]  partial[$];
  logic              exp_ferr  = 1'b0;
  logic [DW_OUT-1:0] last_word = '0;

  task automatic chk(input string name, input logic [DW_OUT-1:0] act, input logic [DW_OUT-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Word = digit k of channel c placed at bit c*BW_OUT + k*BW_IN.
  function automatic logic [DW_OUT-1:0] assemble();
    logic [DW_OUT-1:0] w;
    logic [DW_IN-1:0]  d;
    w = '0;
    for (int k = 0; k < partial.size(); k++) begin
      d = partial[k];
      for (int c = 0; c < NO_CH; c++)
        w[c*BW_OUT + k*BW_IN +: BW_IN] = d[c*BW_IN +: BW_IN];
    end
    return w;
  endfunction

  task automatic step(input bit v, input bit s, input logic [DW_IN-1:0] d, input bit r);
    @(negedge clk);
    #1;
    rst         = r;
    bus.vld_in  = v;
    bus.sof     = s;
    bus.data_in = d;
    @(posedge clk);
    if (r) begin
      partial.delete();
      exp_ferr  = 1'b0;
      last_word = '0;
    end else if (v) begin
      if (s) begin
        if (partial.size() != 0) exp_ferr = 1'b1;
        partial.delete();
      end
      partial.push_back(d);
      if (partial.size() == CYC) begin
        last_word = assemble();
        exp_q.push_back(last_word);
        partial.delete();
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, DW_IN'($urandom), 1'b0);
  endtask

  // Each expected word must appear on the very next sample after its completing edge.
  always @(negedge clk) begin
    logic [DW_OUT-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("vld_out_pulse", DW_OUT'(bus.vld_out), DW_OUT'(1));
      chk("data_out_word", bus.data_out, e);
    end else begin
      chk("vld_out_idle", DW_OUT'(bus.vld_out), '0);
`ifdef FROM_SERIAL_HOLD_EN
      chk("data_out_hold", bus.data_out, last_word);
`else
      chk("data_out_zero", bus.data_out, '0);
`endif
    end
    chk("frame_err", DW_OUT'(bus.frame_err), DW_OUT'(exp_ferr));
  end

  initial begin
    bus.vld_in  = 1'b0;
    bus.sof     = 1'b0;
    bus.data_in = '0;
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    idle(2);

    // basic assembly: ch1 = 0xABCD, ch0 = 0x1234
    step(1'b1, 1'b1, 8'hD4, 1'b0);
    step(1'b1, 1'b0, 8'hC3, 1'b0);
    step(1'b1, 1'b0, 8'hB2, 1'b0);
    step(1'b1, 1'b0, 8'hA1, 1'b0);
    idle(3);

    // gapped input
    step(1'b1, 1'b1, 8'hD4, 1'b0); idle(3);
    step(1'b1, 1'b0, 8'hC3, 1'b0); idle(3);
    step(1'b1, 1'b0, 8'hB2, 1'b0); idle(3);
    step(1'b1, 1'b0, 8'hA1, 1'b0); idle(4);

    // back-to-back words 0x1234 then 0x5678 on ch0
    step(1'b1, 1'b1, {4'($urandom), 4'h4}, 1'b0);
    step(1'b1, 1'b0, {4'($urandom), 4'h3}, 1'b0);
    step(1'b1, 1'b0, {4'($urandom), 4'h2}, 1'b0);
    step(1'b1, 1'b0, {4'($urandom), 4'h1}, 1'b0);
    step(1'b1, 1'b1, {4'($urandom), 4'h8}, 1'b0);
    step(1'b1, 1'b0, {4'($urandom), 4'h7}, 1'b0);
    step(1'b1, 1'b0, {4'($urandom), 4'h6}, 1'b0);
    step(1'b1, 1'b0, {4'($urandom), 4'h5}, 1'b0);
    idle(2);

    // misframe: two digits, then sof + 0xBEEF
    step(1'b1, 1'b1, 8'h11, 1'b0);
    step(1'b1, 1'b0, 8'h22, 1'b0);
    step(1'b1, 1'b1, 8'h0F, 1'b0);
    step(1'b1, 1'b0, 8'h0E, 1'b0);
    step(1'b1, 1'b0, 8'h0E, 1'b0);
    step(1'b1, 1'b0, 8'h0B, 1'b0);
    idle(2);

    // reset mid-word, then 0x00FF without sof
    step(1'b1, 1'b1, 8'h37, 1'b0);
    step(1'b1, 1'b0, 8'h59, 1'b0);
    step(1'b1, 1'b0, 8'h6A, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 8'h0F, 1'b0);
    step(1'b1, 1'b0, 8'h0F, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    idle(1);

    // hold behaviour after 0x1234
    step(1'b1, 1'b1, 8'h04, 1'b0);
    step(1'b1, 1'b0, 8'h03, 1'b0);
    step(1'b1, 1'b0, 8'h02, 1'b0);
    step(1'b1, 1'b0, 8'h01, 1'b0);
    idle(5);

    // random streams with occasional sof misframes and resets
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0,
           DW_IN'($urandom),
           $urandom_range(0, 199) == 0);
    end
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending words, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
